tdc_channel_enable_ctrl: RTL

Parametrised channel-enable controller for the Sigma Delta DAQ TDC array. On a configuration-change notification it requests the channel-enable register, validates and decodes the returned word (per-channel bits plus master switch), and applies the new enable mask. Depending on mode, the mask is applied immediately or at the next frame boundary, so that channels never toggle mid-conversion. It sits between the register bank and the TDC channel bank, and also reports the enabled-channel count and read-timeout errors.

---
 rtl/tdc_channel_enable_pkg.sv | 15 +
 rtl/tdc_channel_enable_ctrl_if.sv | 10 +
 rtl/tdc_channel_enable_ctrl_popcount.sv | 19 +
 rtl/tdc_channel_enable_ctrl.sv | 74 +++++++
 4 files changed

// File: rtl/tdc_channel_enable_pkg.sv
// tdc_channel_enable_pkg: shared state type, defaults and mask decode for the channel-enable controller
package tdc_channel_enable_pkg;
  typedef enum logic [1:0] {IDLE, REQ, PEND} ctrl_state_t;
  localparam int DEF_CHANNEL_COUNT = 16;
  localparam int DEF_REG_WIDTH = 32;
  localparam int DEF_MASTER_BIT = 31;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam bit DEF_SYNC_APPLY = 1'b1;
  localparam int MAX_WIDTH = 64;
  function automatic logic [MAX_WIDTH-1:0] decode_mask(input logic [MAX_WIDTH-1:0] read_data, input int channel_count, input int master_bit);
    logic [MAX_WIDTH-1:0] valid;
    valid = (MAX_WIDTH'(1) << channel_count) - MAX_WIDTH'(1);
    return (read_data[master_bit[5:0]] ? '1 : read_data) & valid;
  endfunction
endpackage

// File: rtl/tdc_channel_enable_ctrl_if.sv
// tdc_channel_enable_ctrl_if: register-bank read handshake between the controller and the register bank
interface tdc_channel_enable_ctrl_if import tdc_channel_enable_pkg::*; #(
  parameter int REG_WIDTH = DEF_REG_WIDTH
);
  logic read_req;
  logic read_ack;
  logic [REG_WIDTH-1:0] read_data;
  modport master(output read_req, input read_ack, input read_data);
  modport slave(input read_req, output read_ack, output read_data);
endinterface

// File: rtl/tdc_channel_enable_ctrl_popcount.sv
// tdc_popcount: registered population count of a bit vector
module tdc_popcount #(
  parameter int WIDTH = 16,
  parameter int CW = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic [WIDTH-1:0] bits,
  output logic [CW-1:0] count
);
  logic [CW-1:0] sum;
  // combinational sum of set bits
  always_comb begin
    sum = '0;
    for (int i = 0; i < WIDTH; i++) sum = sum + CW'(bits[i]);
  end
  // register the count
  always_ff @(posedge clk) count <= reset ? '0 : sum;
endmodule

// File: rtl/tdc_channel_enable_ctrl.sv
// tdc_channel_enable_ctrl: fetches, decodes and applies the TDC channel-enable mask
module tdc_channel_enable_ctrl import tdc_channel_enable_pkg::*; #(
  parameter int CHANNEL_COUNT = DEF_CHANNEL_COUNT,
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int MASTER_BIT = DEF_MASTER_BIT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter bit SYNC_APPLY = DEF_SYNC_APPLY
) (
  input  logic clk,
  input  logic reset,
  input  logic channel_changed,
  tdc_channel_enable_ctrl_if.master bus,
  input  logic frame_sync,
  input  logic force_disable,
  input  logic clear_err,
  output logic [CHANNEL_COUNT-1:0] enable_channels,
  output logic [$clog2(CHANNEL_COUNT+1)-1:0] active_count,
  output logic update_done,
  output logic timeout_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  ctrl_state_t state, state_nxt;
  logic [TW-1:0] cnt;
  logic [CHANNEL_COUNT-1:0] applied, applied_nxt, pending, decoded, enable_nxt;
  logic reread, reread_nxt, ack, expire, apply;
  assign bus.read_req = state == REQ;
  assign decoded = CHANNEL_COUNT'(decode_mask(MAX_WIDTH'(REG_WIDTH'(bus.read_data)), CHANNEL_COUNT, MASTER_BIT));
  assign ack = state == REQ && bus.read_ack;
  assign expire = state == REQ && !bus.read_ack && cnt == TW'(TIMEOUT_CYCLES - 1);
  assign apply = SYNC_APPLY ? state == PEND && frame_sync : ack;
  assign applied_nxt = apply ? (SYNC_APPLY ? pending : decoded) : applied;
  assign enable_nxt = force_disable ? '0 : applied_nxt;
  // next state; changes after the first request cycle or while pending are folded into one re-read
  always_comb begin
    state_nxt = state == IDLE ? ((channel_changed || reread) ? REQ : IDLE)
              : state == REQ ? (ack ? (SYNC_APPLY ? PEND : IDLE) : (expire ? IDLE : REQ))
              : (frame_sync ? IDLE : PEND);
    reread_nxt = state == IDLE ? 1'b0 : reread || (channel_changed && (state == PEND || cnt != '0));
  end
  // FSM state, request-age counter and re-read flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      reread <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= state == REQ ? cnt + TW'(1) : '0;
      reread <= reread_nxt;
    end
  end
  // mask datapath, completion pulse and sticky timeout error
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      applied <= '0;
      enable_channels <= '0;
      update_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      pending <= ack ? decoded : pending;
      applied <= applied_nxt;
      enable_channels <= enable_nxt;
      update_done <= apply;
      timeout_err <= expire || (timeout_err && !clear_err);
    end
  end
  tdc_popcount #(.WIDTH(CHANNEL_COUNT)) u_popcount (
    .clk(clk),
    .reset(reset),
    .bits(enable_nxt),
    .count(active_count)
  );
endmodule
